usr_shift_sequencer: RTL
========================

// Module: usr_shift_sequencer
// PURPOSE
//  Command sequencer directly upstream of the universal shift register stage.
//  Accepts load/shift/hold commands over a valid/ready handshake.
//  Expands each command into the per-cycle mode, data_in and parallel_in drive the register consumes.
//  Lets the datapath stream a WIDTH-bit word in serially, or load it in one cycle, with no per-cycle CPU control.
// PARAMETERS
//  WIDTH     4       register width / parallel_in width
//  CNT_W     3       length counter width, $clog2(WIDTH+1)
//  MODE_HOLD 3'b000  mode code: hold
//  MODE_SHR  3'b001  mode code: shift right, data_in enters MSB
//  MODE_LOAD 3'b010  mode code: parallel load
//  MODE_SHL  3'b100  mode code: shift left, data_in enters LSB
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      sequencer can accept (state==IDLE)
//  cmd_op       in   2      00 LOAD, 01 SHIFT_R, 10 SHIFT_L, 11 WAIT
//  cmd_data     in   WIDTH  load word, or serial source bits
//  cmd_len      in   CNT_W  active cycles for SHIFT_*/WAIT; ignored for LOAD
//  abort        in   1      only with USR_SEQ_ABORT_EN
//  mode         out  3      to shift register mode
//  data_in      out  1      to shift register serial input
//  parallel_in  out  WIDTH  to shift register parallel_in_[WIDTH-1:0]
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle pulse on command completion
// BEHAVIOUR
//  Reset (async, any cycle):
//   - state=IDLE, mode=MODE_HOLD, data_in=0, parallel_in=0, done=0, busy=0.
//   - Counter and captured data cleared; an in-flight command is dropped silently.
//  Accept rule and capture:
//   - Accept on clk edge T when cmd_valid && cmd_ready.
//   - Capture op, data, len; eff_len = min(cmd_len, WIDTH).
//   - While busy, cmd_valid is ignored; the command must stay stable until accepted.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE -> RUN on accept. Exception: SHIFT_*/WAIT with eff_len==0 goes IDLE -> DONE.
//   - RUN: LOAD is 1 cycle (T+1) with mode=MODE_LOAD and parallel_in=cmd_data.
//   - RUN: SHIFT_R/SHIFT_L lasts eff_len cycles. Cycle k drives mode=MODE_SHR/SHL and data_in=cmd_data[k] (LSB first).
//   - RUN: WAIT lasts eff_len cycles with mode=MODE_HOLD.
//   - RUN -> DONE after the last active cycle.
//   - DONE: one cycle; done=1, mode=MODE_HOLD, data_in=0. DONE -> IDLE.
//  Latency and throughput:
//   - All outputs are registered; first active drive is at T+1.
//   - LOAD: done at T+2; cmd_ready high again at T+3.
//   - Back-to-back rate is one command per eff_len+2 cycles; zero-length commands take 2 cycles.
//  Output rules:
//   - parallel_in holds its last loaded value outside LOAD cycles.
//   - mode is MODE_HOLD in every non-RUN cycle.
//  Counter: down-counter loaded with eff_len; RUN exits when count reaches 1. No wrap.
// CONFIGURATION
//  USR_SEQ_ABORT_EN defined:
//   - abort=1 in RUN or DONE forces IDLE at the next edge, mode=MODE_HOLD, data_in=0, done stays 0.
//   - abort in IDLE is ignored; abort has priority over accept in the same cycle.
//  USR_SEQ_ABORT_EN undefined:
//   - abort port absent; commands always run to completion.
// TESTING (WIDTH=4)
//  LOAD 4'b0101:
//   - T+1 mode=010, parallel_in=0101; T+2 done=1, mode=000; T+3 cmd_ready=1.
//  SHIFT_R data=4'b0101 len=3:
//   - T+1..T+3 mode=001 with data_in=1,0,1; T+4 done=1, mode=000.
//  SHIFT_L len=7:
//   - Clamped to 4 active cycles (mode=100); done at T+5.
//  SHIFT_R len=0:
//   - No active cycle; T+1 done=1, mode=000.
//  Reset asserted mid-SHIFT (asynchronously, between edges):
//   - Outputs go to mode=000, data_in=0, busy=0 without a clock edge.
//   - No done pulse afterwards; the next command is accepted normally.
//  Busy blocking:
//   - cmd_valid held high during RUN -> no second accept until IDLE.
//  With USR_SEQ_ABORT_EN, abort during SHIFT cycle 2:
//   - Next edge mode=000, done never pulses.

Source files
------------

// File: rtl/usr_shift_sequencer_if.sv
// Command channel into usr_shift_sequencer: valid/ready handshake carrying op, data and length.
interface usr_shift_sequencer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/usr_shift_sequencer.sv
// Expands load/shift/wait commands into per-cycle drive for a universal shift register.
// Optional abort input is compiled in when USR_SEQ_ABORT_EN is defined.
module usr_shift_sequencer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_W     = 3,
    parameter logic [2:0]  MODE_HOLD = 3'b000,
    parameter logic [2:0]  MODE_SHR  = 3'b001,
    parameter logic [2:0]  MODE_LOAD = 3'b010,
    parameter logic [2:0]  MODE_SHL  = 3'b100
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef USR_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    usr_shift_sequencer_if.slave cmd,
    output logic [2:0]           mode,
    output logic                 data_in,
    output logic [WIDTH-1:0]     parallel_in,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0]       OpLoad = 2'b00;
    localparam logic [1:0]       OpShr  = 2'b01;
    localparam logic [1:0]       OpShl  = 2'b10;
    localparam logic [1:0]       OpWait = 2'b11;
    localparam logic [CNT_W-1:0] MaxLen = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CNT_W-1:0] eff_len;
    logic [2:0]       run_mode;
    logic             accept;
    logic             abort_req;

`ifdef USR_SEQ_ABORT_EN
    assign abort_req = abort && (state_q != StIdle);
`else
    assign abort_req = 1'b0;
`endif

    assign eff_len       = (cmd.cmd_len > MaxLen) ? MaxLen : cmd.cmd_len;
    assign cmd.cmd_ready = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        run_mode = MODE_HOLD;
        unique case (cmd.cmd_op)
            OpShr:   run_mode = MODE_SHR;
            OpShl:   run_mode = MODE_SHL;
            default: run_mode = MODE_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OpLoad;
            data_q      <= '0;
            cnt_q       <= '0;
            mode        <= MODE_HOLD;
            data_in     <= 1'b0;
            parallel_in <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_req) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                mode    <= MODE_HOLD;
                data_in <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            op_q   <= cmd.cmd_op;
                            // Serial bits go out LSB first; bit 0 is driven straight away.
                            data_q <= cmd.cmd_data >> 1;
                            if (cmd.cmd_op == OpLoad) begin
                                state_q     <= StRun;
                                cnt_q       <= One;
                                mode        <= MODE_LOAD;
                                data_in     <= 1'b0;
                                parallel_in <= cmd.cmd_data;
                            end else if (eff_len == '0) begin
                                state_q <= StDone;
                                cnt_q   <= '0;
                                mode    <= MODE_HOLD;
                                data_in <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state_q <= StRun;
                                cnt_q   <= eff_len;
                                mode    <= run_mode;
                                data_in <= (cmd.cmd_op == OpWait) ? 1'b0 : cmd.cmd_data[0];
                            end
                        end
                    end
                    StRun: begin
                        if (cnt_q <= One) begin
                            state_q <= StDone;
                            cnt_q   <= '0;
                            mode    <= MODE_HOLD;
                            data_in <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q - One;
                            data_in <= (op_q == OpWait) ? 1'b0 : data_q[0];
                            data_q  <= data_q >> 1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        mode    <= MODE_HOLD;
                        data_in <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
